// File: rtl/fp_resp_pkg.sv
// Shared types and constants for the AWP request responder (fp_resp).
package fp_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MEM  = 3'd1,
    ST_REG  = 3'd2,
    ST_DONE = 3'd3,
    ST_FAIL = 3'd4
  } state_e;

  // Register index carried on the LP counter bits {lpb,lpa}; index 0 selects nothing.
  localparam logic [1:0] LP_NONE = 2'd0;
  localparam logic [1:0] LP_R1   = 2'd1;
  localparam logic [1:0] LP_R2   = 2'd2;
  localparam logic [1:0] LP_R3   = 2'd3;

  // Number of MEM cycles with mem_rq high before a memory read is abandoned.
  localparam logic [7:0] TMO_CYCLES = 8'd255;

endpackage

// File: rtl/fp_resp_if.sv
// Bundle of the AWP request side, the memory port and the register file port of fp_resp.
// master = environment (AWP, memory, register file); slave = fp_resp.
interface fp_resp_if;
  // AWP request side
  logic        sr_fp;
  logic        read_fp;
  logic        rlp_fp;
  logic        s_fp;
  logic        lpa;
  logic        lpb;
  logic [15:0] ar;
  logic [15:0] w_in;
  logic [15:0] rd_out;
  logic        ok_fp;
  logic        alarm_fp;
  logic        busy;
  // Memory port
  logic        mem_rq;
  logic [15:0] mem_ad;
  logic        mem_ack;
  logic [15:0] mem_di;
  // Register file port
  logic [1:0]  rf_sel;
  logic        rf_we;
  logic [15:0] rf_wd;
  logic [15:0] rf_rd;

  modport master (
    output sr_fp, read_fp, rlp_fp, s_fp, lpa, lpb, ar, w_in,
    input  rd_out, ok_fp, alarm_fp, busy,
    input  mem_rq, mem_ad,
    output mem_ack, mem_di,
    input  rf_sel, rf_we, rf_wd,
    output rf_rd
  );

  modport slave (
    input  sr_fp, read_fp, rlp_fp, s_fp, lpa, lpb, ar, w_in,
    output rd_out, ok_fp, alarm_fp, busy,
    output mem_rq, mem_ad,
    input  mem_ack, mem_di,
    output rf_sel, rf_we, rf_wd,
    input  rf_rd
  );
endinterface

// File: rtl/fp_resp_tmo.sv
// Memory-read watchdog for fp_resp: counts MEM cycles and flags expiry at TMO_CYCLES.
// Only instantiated when FP_RESP_TIMEOUT_EN is defined.
module fp_resp_tmo
  import fp_resp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,      // entering MEM: restart the count
  input  logic run_i,      // currently in MEM
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == TMO_CYCLES);

  // Next count: clear on MEM entry, otherwise count MEM cycles and saturate at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !expired_o) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fp_resp.sv
// fp_resp: answers AWP interface requests with a memory read or an r1..r3 register access.
// Optional feature macro: FP_RESP_TIMEOUT_EN (memory-read watchdog; default build waits forever).
module fp_resp
  import fp_resp_pkg::*;
(
  input logic      __clk,
  input logic      rst_,
  fp_resp_if.slave bus
);

  state_e      state_q, state_d;
  logic        sr_q;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] wd_q, wd_d;
  logic        wr_q, wr_d;
  logic [15:0] rd_q, rd_d;
  logic [1:0]  lp_idx;
  logic        req_edge;
  logic        tmo_expired;

  assign lp_idx   = {bus.lpb, bus.lpa};
  // A new request is a rising edge of sr_fp against its registered copy; holding it high never re-fires.
  assign req_edge = bus.sr_fp & ~sr_q;

`ifdef FP_RESP_TIMEOUT_EN
  logic tmo_clr;
  assign tmo_clr = (state_q == ST_IDLE) && req_edge && bus.read_fp;

  fp_resp_tmo u_tmo (
    .clk       (__clk),
    .rst_n     (rst_),
    .clr_i     (tmo_clr),
    .run_i     (state_q == ST_MEM),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // Next-state and request latching: decode only in IDLE, read > register > no-op.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          if (bus.read_fp) begin
            addr_d  = bus.ar;
            state_d = ST_MEM;
          end else if (bus.rlp_fp) begin
            sel_d   = lp_idx;
            wd_d    = bus.w_in;
            wr_d    = bus.s_fp;
            state_d = (lp_idx == LP_NONE) ? ST_FAIL : ST_REG;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MEM: begin
        if (tmo_expired) begin
          state_d = ST_FAIL;
        end else if (bus.mem_ack) begin
          rd_d    = bus.mem_di;
          state_d = ST_DONE;
        end
      end
      ST_REG: begin
        if (!wr_q) begin
          rd_d = bus.rf_rd;
        end
        state_d = ST_DONE;
      end
      ST_DONE, ST_FAIL: state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset returns everything visible to zero.
  always_ff @(posedge __clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      sr_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      sr_q    <= bus.sr_fp;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs are decoded from registered state only; REG lasts one cycle so rf_we is a single pulse.
  assign bus.mem_rq   = (state_q == ST_MEM) && !tmo_expired;
  assign bus.mem_ad   = addr_q;
  assign bus.rf_sel   = sel_q;
  assign bus.rf_wd    = wd_q;
  assign bus.rf_we    = (state_q == ST_REG) && wr_q;
  assign bus.rd_out   = rd_q;
  assign bus.ok_fp    = (state_q == ST_DONE);
  assign bus.alarm_fp = (state_q == ST_FAIL);
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_resp.sv
// Directed bench for fp_resp: scoreboard of expected rd_out values checked on each ok_fp.
// Timeout scenario follows FP_RESP_TIMEOUT_EN the same way the RTL does.
module tb_fp_resp;
  import fp_resp_pkg::*;

  logic        clk;
  logic        rst_n;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb [$];
  logic [15:0] rd_model;
  logic [15:0] rf [4];

  fp_resp_if bus ();

  fp_resp dut (
    .__clk (clk),
    .rst_  (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model behind the DUT's register port.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf[0] <= 16'h0000;
      rf[1] <= 16'h1111;
      rf[2] <= 16'h2222;
      rf[3] <= 16'hA5A5;
    end else if (bus.rf_we) begin
      rf[bus.rf_sel] <= bus.rf_wd;
    end
  end
  assign bus.rf_rd = rf[bus.rf_sel];

  // Watchdog so a wedged run still terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the drive/sample point 2 time units after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a request in the current cycle (cycle N).
  task automatic start(input logic rd, input logic rlp, input logic s, input logic [1:0] idx,
                       input logic [15:0] a, input logic [15:0] w);
    bus.read_fp = rd;
    bus.rlp_fp  = rlp;
    bus.s_fp    = s;
    bus.lpb     = idx[1];
    bus.lpa     = idx[0];
    bus.ar      = a;
    bus.w_in    = w;
    bus.sr_fp   = 1'b1;
  endtask

  task automatic idle_inputs();
    bus.sr_fp   = 1'b0;
    bus.read_fp = 1'b0;
    bus.rlp_fp  = 1'b0;
    bus.s_fp    = 1'b0;
    bus.lpa     = 1'b0;
    bus.lpb     = 1'b0;
    bus.ar      = 16'h0000;
    bus.w_in    = 16'h0000;
  endtask

  // Completion cycle: ok_fp high, no alarm, rd_out equals the oldest scoreboard entry.
  task automatic check_done(input string tag);
    logic [15:0] exp;
    check({tag, "_ok"}, bus.ok_fp, 1'b1);
    check({tag, "_noalarm"}, bus.alarm_fp, 1'b0);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s_sb: observed completion expected none queued", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, "_rd"}, bus.rd_out, exp);
    end
  endtask

  initial begin
    int rq_cnt, alarm_cnt, ok_cnt, rq_low_at, alarm_at;
    logic [1:0] idx;

    rst_n       = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_di  = 16'h0000;
    idle_inputs();
    rd_model = 16'h0000;

    // Reset state
    tick(); tick();
    check("rst_busy",   bus.busy,     1'b0);
    check("rst_mem_rq", bus.mem_rq,   1'b0);
    check("rst_rf_we",  bus.rf_we,    1'b0);
    check("rst_ok",     bus.ok_fp,    1'b0);
    check("rst_alarm",  bus.alarm_fp, 1'b0);
    check("rst_rd_out", bus.rd_out,   16'h0000);
    check("rst_rf_sel", bus.rf_sel,   2'd0);
    check("rst_mem_ad", bus.mem_ad,   16'h0000);
    rst_n = 1'b1;
    tick();

    // Memory read: ack at N+3, ok_fp at N+4
    start(1'b1, 1'b0, 1'b0, 2'd0, 16'h1234, 16'h0000);
    rd_model = 16'hBEEF; sb.push_back(rd_model);
    check("mr_n_busy", bus.busy, 1'b0);
    tick(); // N+1
    idle_inputs();
    check("mr_n1_rq",   bus.mem_rq, 1'b1);
    check("mr_n1_ad",   bus.mem_ad, 16'h1234);
    check("mr_n1_busy", bus.busy,   1'b1);
    check("mr_n1_ok",   bus.ok_fp,  1'b0);
    tick(); // N+2
    check("mr_n2_rq", bus.mem_rq, 1'b1);
    tick(); // N+3
    bus.mem_ack = 1'b1; bus.mem_di = 16'hBEEF;
    check("mr_n3_rq", bus.mem_rq, 1'b1);
    check("mr_n3_ok", bus.ok_fp,  1'b0);
    tick(); // N+4
    bus.mem_ack = 1'b0; bus.mem_di = 16'h0000;
    check_done("mr_n4");
    check("mr_n4_rq", bus.mem_rq, 1'b0);
    tick(); // N+5
    check("mr_n5_ok",   bus.ok_fp, 1'b0);
    check("mr_n5_busy", bus.busy,  1'b0);

    // mem_ack outside MEM is ignored
    bus.mem_ack = 1'b1; bus.mem_di = 16'hFFFF;
    tick();
    bus.mem_ack = 1'b0; bus.mem_di = 16'h0000;
    tick();
    check("ack_idle_rd",   bus.rd_out, rd_model);
    check("ack_idle_busy", bus.busy,   1'b0);

    // Register write r2 <= 0x00FF
    start(1'b0, 1'b1, 1'b1, LP_R2, 16'h0000, 16'h00FF);
    sb.push_back(rd_model);
    tick(); // N+1
    idle_inputs();
    check("rw_n1_we",  bus.rf_we,  1'b1);
    check("rw_n1_sel", bus.rf_sel, 2'd2);
    check("rw_n1_wd",  bus.rf_wd,  16'h00FF);
    check("rw_n1_ok",  bus.ok_fp,  1'b0);
    tick(); // N+2
    check("rw_n2_we", bus.rf_we, 1'b0);
    check_done("rw_n2");
    tick();

    // Register reads r2 (just written), r1, r3
    for (int k = 0; k < 3; k++) begin
      idx = (k == 0) ? LP_R2 : ((k == 1) ? LP_R1 : LP_R3);
      start(1'b0, 1'b1, 1'b0, idx, 16'h0000, 16'hDEAD);
      rd_model = (k == 0) ? 16'h00FF : ((k == 1) ? 16'h1111 : 16'hA5A5);
      sb.push_back(rd_model);
      tick(); // N+1
      idle_inputs();
      check($sformatf("rr%0d_we", k),  bus.rf_we,  1'b0);
      check($sformatf("rr%0d_sel", k), bus.rf_sel, idx);
      tick(); // N+2
      check_done($sformatf("rr%0d", k));
      tick();
    end

    // Register access with index 00: alarm at N+1, no write, no ok
    start(1'b0, 1'b1, 1'b1, LP_NONE, 16'h0000, 16'h5555);
    tick(); // N+1
    idle_inputs();
    check("bad_n1_alarm", bus.alarm_fp, 1'b1);
    check("bad_n1_ok",    bus.ok_fp,    1'b0);
    check("bad_n1_we",    bus.rf_we,    1'b0);
    tick(); // N+2
    check("bad_n2_alarm", bus.alarm_fp, 1'b0);
    check("bad_n2_ok",    bus.ok_fp,    1'b0);
    check("bad_n2_busy",  bus.busy,     1'b0);
    check("bad_n2_rd",    bus.rd_out,   rd_model);

    // No-op request: ok at N+1, rd_out unchanged
    start(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 16'h0000);
    sb.push_back(rd_model);
    tick();
    idle_inputs();
    check_done("nop_n1");
    tick();

    // Second edge during a pending read is ignored; held-high sr_fp never re-triggers
    start(1'b1, 1'b0, 1'b0, 2'd0, 16'h0042, 16'h0000);
    rd_model = 16'h5A5A; sb.push_back(rd_model);
    tick(); // N+1
    idle_inputs();
    tick(); // N+2
    bus.sr_fp = 1'b1;
    tick(); // N+3
    bus.mem_ack = 1'b1; bus.mem_di = 16'h5A5A;
    tick(); // N+4
    bus.mem_ack = 1'b0;
    check_done("dbl_n4");
    ok_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.ok_fp || bus.busy) ok_cnt++;
    end
    check("dbl_no_retrigger", ok_cnt, 0);
    bus.sr_fp = 1'b0;
    tick();

    // Reset at N+2 of a memory read, then release with sr_fp already high
    start(1'b1, 1'b0, 1'b0, 2'd0, 16'h0777, 16'h0000);
    tick(); // N+1
    idle_inputs();
    tick(); // N+2
    rst_n = 1'b0;
    #1;
    check("rst_mid_rq",   bus.mem_rq, 1'b0);
    check("rst_mid_busy", bus.busy,   1'b0);
    check("rst_mid_rd",   bus.rd_out, 16'h0000);
    check("rst_mid_ad",   bus.mem_ad, 16'h0000);
    rd_model = 16'h0000;
    bus.sr_fp = 1'b1; // no-op request pending across reset release
    tick();
    check("rst_mid_ok", bus.ok_fp, 1'b0);
    tick();
    rst_n = 1'b1;
    sb.push_back(rd_model);
    tick(); // first edge after release sees the 0->1 edge
    check_done("rel_edge");
    tick();
    check("rel_busy", bus.busy, 1'b0);
    bus.sr_fp = 1'b0;
    tick();

    // Memory read with no acknowledge
    start(1'b1, 1'b0, 1'b0, 2'd0, 16'h0ABC, 16'h0000);
    rq_cnt = 0; alarm_cnt = 0; ok_cnt = 0; rq_low_at = -1; alarm_at = -1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 0) idle_inputs();
      if (bus.mem_rq) rq_cnt++;
      else if (rq_low_at < 0) rq_low_at = i;
      if (bus.alarm_fp) begin
        alarm_cnt++;
        if (alarm_at < 0) alarm_at = i;
      end
      if (bus.ok_fp) ok_cnt++;
    end
`ifdef FP_RESP_TIMEOUT_EN
    check("tmo_rq_cycles", rq_cnt,    255);
    check("tmo_rq_low_at", rq_low_at, 255);
    check("tmo_alarm_at",  alarm_at,  256);
    check("tmo_alarm_cnt", alarm_cnt, 1);
    check("tmo_no_ok",     ok_cnt,    0);
    check("tmo_busy_end",  bus.busy,  1'b0);
`else
    check("wait_rq_cycles", rq_cnt,    300);
    check("wait_no_alarm",  alarm_cnt, 0);
    check("wait_no_ok",     ok_cnt,    0);
    rd_model = 16'hC0DE; sb.push_back(rd_model);
    bus.mem_ack = 1'b1; bus.mem_di = 16'hC0DE;
    tick();
    bus.mem_ack = 1'b0;
    check_done("wait_ack");
`endif
    tick();
    check("end_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_resp.md
FP_RESP -- requirements
Module: fp_resp

Interface
REQ-001 __clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst_  in  1  asynchronous active-low reset.
REQ-003 sr_fp  in  1  AWP interface access request; level, new request = 0->1 transition.
REQ-004 read_fp  in  1  request is a memory read.
REQ-005 rlp_fp  in  1  request is an r1..r3 register access selected by the LP counter.
REQ-006 s_fp  in  1  register access direction: 1 = write, 0 = read.
REQ-007 lpa, lpb  in  1 each  LP counter bits, {lpb,lpa} = register index.
REQ-008 ar  in  16  memory address for a memory read.
REQ-009 w_in  in  16  write data for a register write.
REQ-010 rd_out  out  16  returned data (memory word or register value).
REQ-011 ok_fp  out  1  one-cycle completion strobe to AWP.
REQ-012 alarm_fp  out  1  one-cycle failure strobe (bad index or timeout).
REQ-013 busy  out  1  high from accepted request to ok_fp/alarm_fp cycle inclusive.
REQ-014 mem_rq, mem_ad  out  1/16  memory request and address; mem_ack, mem_di  in  1/16  memory acknowledge and data.
REQ-015 rf_sel  out  2;  rf_we  out  1;  rf_wd  out  16;  rf_rd  in  16  register file port.

Function
REQ-016 sr_fp SHALL be registered; a request is accepted on the cycle N a 0->1 edge is seen in IDLE.
REQ-017 Edges while busy SHALL be ignored; sr_fp held high SHALL NOT re-trigger.
REQ-018 Decode priority at cycle N: read_fp -> MEM; else rlp_fp -> REG; else NOP.
REQ-019 States: IDLE, MEM, REG, DONE, FAIL; DONE/FAIL SHALL last exactly one cycle then go to IDLE.
REQ-020 MEM: mem_rq=1 and mem_ad=ar (latched at N) from N+1 until the mem_ack cycle inclusive; mem_di latched into rd_out on the ack cycle; DONE next cycle.
REQ-021 mem_ack outside MEM SHALL be ignored.
REQ-022 REG: in cycle N+1 rf_sel={lpb,lpa} (latched at N), rf_we=s_fp, rf_wd=w_in (latched at N); read latches rf_rd into rd_out at N+1; DONE at N+2.
REQ-023 REG with index 00 SHALL produce no rf_we and go to FAIL at N+1.
REQ-024 NOP SHALL go to DONE at N+1 with rd_out unchanged.
REQ-025 ok_fp=1 exactly in DONE; alarm_fp=1 exactly in FAIL; never both.
REQ-026 rd_out SHALL hold its value until the next successful read.
REQ-027 rf_we SHALL be high for at most one cycle per request.

Reset
REQ-028 rst_ low at any time, including mid-MEM, SHALL force IDLE, mem_rq=0, rf_we=0, ok_fp=0, alarm_fp=0, busy=0, rd_out=0, rf_sel=0, mem_ad=0, sr_fp sample register=0.
REQ-029 After release, sr_fp already high SHALL count as an edge.

Configuration
REQ-030 With FP_RESP_TIMEOUT_EN defined: an 8-bit counter cleared on MEM entry; after 255 MEM cycles without mem_ack, mem_rq drops and FAIL follows the next cycle.
REQ-031 Without FP_RESP_TIMEOUT_EN: MEM waits indefinitely; alarm_fp arises only from REQ-023.

Structure
REQ-032 Package fp_resp_pkg SHALL hold the state enum, LP index constants (LP_NONE=0, LP_R1..LP_R3) and TMO_CYCLES=255.
REQ-033 Timeout counter SHALL be a sub-module fp_resp_tmo, instantiated only under FP_RESP_TIMEOUT_EN.

Verification
REQ-034 read_fp=1, ar=0x1234, sr_fp edge at N; mem_ack with mem_di=0xBEEF at N+3 -> mem_rq=1 N+1..N+3, rd_out=0xBEEF, ok_fp only at N+4.
REQ-035 rlp_fp=1, s_fp=1, {lpb,lpa}=10, w_in=0x00FF -> rf_we=1, rf_sel=2, rf_wd=0x00FF at N+1 only; ok_fp at N+2.
REQ-036 rlp_fp=1, {lpb,lpa}=00 -> no rf_we; alarm_fp at N+1; ok_fp never.
REQ-037 Second sr_fp edge at N+2 of a pending memory read -> ignored; exactly one ok_fp.
REQ-038 rst_ low at N+2 of a memory read -> mem_rq=0, busy=0 immediately; no ok_fp.
REQ-039 FP_RESP_TIMEOUT_EN defined, no mem_ack -> mem_rq low after 255 MEM cycles, alarm_fp one cycle later, then IDLE.
